approx_mul_pipe: RTL
====================

APPROX_MUL_PIPE -- requirements
Module: approx_mul_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width; SHALL be even and 8..32.
REQ-002 Parameter TRUNC, default 2, low bits zeroed in an approximate quadrant product; SHALL be 0..WIDTH-1.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  One clock; reset is asynchronous and active-low.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  WIDTH  unsigned operands.
REQ-008 mode  input  4  per-quadrant approx enable: bit0 LL, bit1 LH (a_lo*b_hi), bit2 HL (a_hi*b_lo), bit3 HH; 1 = approximate.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 prod  output  2*WIDTH  product.

Function
REQ-012 Operands SHALL be split at H=WIDTH/2 into a_hi, a_lo, b_hi, b_lo; four H x H quadrant products are formed.
REQ-013 Exact quadrant product SHALL be full 2H-bit product; approximate quadrant product = exact product with bits [TRUNC-1:0] forced to 0.
REQ-014 prod SHALL equal HH<<WIDTH + (HL+LH)<<H + LL, computed at 2*WIDTH bits, no overflow possible.
REQ-015 Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-016 Pipeline SHALL be 3 stages: S1 register a, b, mode; S2 register four quadrant products; S3 register summed prod. Latency 3 cycles from accept to out_valid with no stall.
REQ-017 mode SHALL be sampled with its operands at accept; later mode changes SHALL not affect in-flight data.
REQ-018 Each stage holds a valid bit; a stage advances when its successor is empty or advancing (per-stage bubble-collapsing).
REQ-019 in_ready SHALL be high when S1 is empty or S1 advances this cycle; combinational from out_ready allowed.
REQ-020 With out_valid high and out_ready low, prod and out_valid SHALL hold stable until the transfer.
REQ-021 Full throughput: with out_ready held high, one result per cycle, in-order.
REQ-022 Up to 3 results may be buffered under backpressure; a fourth SHALL be refused (in_ready low).

Reset
REQ-023 rst_n low SHALL asynchronously clear all stage valid bits; out_valid=0, prod=0, in_ready=1 after release.
REQ-024 Reset mid-operation SHALL discard all in-flight results; none SHALL appear after release.
REQ-025 Data registers other than prod need not be reset.

Configuration
REQ-026 Macro APPROX_ERR_STAT_EN: when defined, add outputs err_cnt (32) and err_max (2*WIDTH); when undefined, ports and logic absent.
REQ-027 With APPROX_ERR_STAT_EN, each output transfer SHALL compute exact product minus prod (non-negative); if nonzero err_cnt increments (saturating at all-ones); err_max holds the largest difference seen.
REQ-028 err_cnt and err_max SHALL reset to 0 with rst_n.

Structure
REQ-029 Package approx_mul_pkg SHALL hold mode bit index constants (MODE_LL=0, MODE_LH=1, MODE_HL=2, MODE_HH=3) and the WIDTH/TRUNC legality check function.
REQ-030 One sub-module approx_quad_mul (H x H, approx enable, TRUNC parameter, combinational) SHALL be instantiated four times.
REQ-031 Stage control and summation SHALL live in approx_mul_pipe.

Verification
REQ-032 WIDTH=8, TRUNC=2, mode=0, a=255, b=255, out_ready=1 -> prod=65025 exactly 3 cycles after accept.
REQ-033 WIDTH=8, TRUNC=2, mode=4'b0001, a=0x0F, b=0x0F -> LL=225 truncated to 224, prod=224; with APPROX_ERR_STAT_EN err_cnt=1, err_max=1.
REQ-034 mode=4'b1111, a=0xFF, b=0xFF, TRUNC=2 -> quadrants 224 each, prod=224*256*... i.e. 57344+2*3584+224=64736.
REQ-035 Back-to-back 100 random operands, out_ready held low 5 cycles mid-stream -> in_ready drops after 3 buffered, no loss/duplication, order preserved, held prod stable.
REQ-036 rst_n asserted with 3 results in flight -> out_valid=0 immediately; after release no stale output; first new op returns correct prod at latency 3.
REQ-037 mode toggled every cycle during stream -> each result matches the mode sampled at its accept.

Source files
------------

// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg: shared mode-bit indices and parameter legality check for the approximate multiplier
package approx_mul_pkg;
  localparam int MODE_LL = 0;
  localparam int MODE_LH = 1;
  localparam int MODE_HL = 2;
  localparam int MODE_HH = 3;
  function automatic bit legal_cfg(int width, int trunc);
    return (width % 2 == 0) && (width >= 8) && (width <= 32) && (trunc >= 0) && (trunc < width);
  endfunction
endpackage

// File: rtl/approx_quad_mul.sv
// approx_quad_mul: combinational H x H quadrant product, optionally zeroing the low TRUNC bits
module approx_quad_mul #(
  parameter int H     = 4,
  parameter int TRUNC = 2
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  input  logic           approx,
  output logic [2*H-1:0] p
);
  localparam logic [2*H-1:0] KEEP = {(2*H){1'b1}} << TRUNC;
  logic [2*H-1:0] full;
  assign full = (2*H)'(x) * (2*H)'(y);
  assign p    = approx ? (full & KEEP) : full;
endmodule

// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: 3-stage valid/ready approximate multiplier; APPROX_ERR_STAT_EN adds error statistics outputs
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
`ifdef APPROX_ERR_STAT_EN
  ,
  output logic [31:0]        err_cnt,
  output logic [2*WIDTH-1:0] err_max
`endif
);
  localparam int H = WIDTH / 2;
  localparam int P = 2 * WIDTH;
  if (!legal_cfg(WIDTH, TRUNC)) begin : g_bad_cfg
    $error("approx_mul_pipe: illegal WIDTH/TRUNC");
  end
  logic             v1_q, v2_q, v3_q;
  logic             ld1, ld2, ld3;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       m_q;
  logic [WIDTH-1:0] ll_d, lh_d, hl_d, hh_d;
  logic [WIDTH-1:0] ll_q, lh_q, hl_q, hh_q;
  logic [P-1:0]     prod_d, prod_q;
  assign ld3       = !v3_q || out_ready;
  assign ld2       = !v2_q || ld3;
  assign ld1       = !v1_q || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3_q;
  assign prod      = prod_q;
  approx_quad_mul #(.H(H), .TRUNC(TRUNC)) u_ll (.x(a_q[H-1:0]),     .y(b_q[H-1:0]),     .approx(m_q[MODE_LL]), .p(ll_d));
  approx_quad_mul #(.H(H), .TRUNC(TRUNC)) u_lh (.x(a_q[H-1:0]),     .y(b_q[WIDTH-1:H]), .approx(m_q[MODE_LH]), .p(lh_d));
  approx_quad_mul #(.H(H), .TRUNC(TRUNC)) u_hl (.x(a_q[WIDTH-1:H]), .y(b_q[H-1:0]),     .approx(m_q[MODE_HL]), .p(hl_d));
  approx_quad_mul #(.H(H), .TRUNC(TRUNC)) u_hh (.x(a_q[WIDTH-1:H]), .y(b_q[WIDTH-1:H]), .approx(m_q[MODE_HH]), .p(hh_d));
  assign prod_d = (P'(hh_q) << WIDTH) + ((P'(hl_q) + P'(lh_q)) << H) + P'(ll_q);
  // stage occupancy: each stage loads when its successor is empty or draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (ld1) v1_q <= in_valid;
      if (ld2) v2_q <= v1_q;
      if (ld3) v3_q <= v2_q;
    end
  end
  // operand and quadrant-product registers carry no reset; valid bits guard them
  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      a_q <= a;
      b_q <= b;
      m_q <= mode;
    end
    if (ld2 && v1_q) begin
      ll_q <= ll_d;
      lh_q <= lh_d;
      hl_q <= hl_d;
      hh_q <= hh_d;
    end
  end
  // summed result register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod_q <= '0;
    else if (ld3 && v2_q) prod_q <= prod_d;
  end
`ifdef APPROX_ERR_STAT_EN
  logic [P-1:0]  ex2_q, ex3_q, diff, err_max_d, err_max_q;
  logic [31:0]   err_cnt_d, err_cnt_q;
  logic          xfer;
  assign xfer      = v3_q && out_ready;
  assign diff      = ex3_q - prod_q;
  assign err_cnt_d = (xfer && diff != '0 && err_cnt_q != '1) ? err_cnt_q + 32'd1 : err_cnt_q;
  assign err_max_d = (xfer && diff > err_max_q) ? diff : err_max_q;
  assign err_cnt   = err_cnt_q;
  assign err_max   = err_max_q;
  // exact product travels alongside the approximate one for error measurement
  always_ff @(posedge clk) begin
    if (ld2 && v1_q) ex2_q <= P'(a_q) * P'(b_q);
    if (ld3 && v2_q) ex3_q <= ex2_q;
  end
  // error statistics accumulate on each output transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      err_max_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_max_q <= err_max_d;
    end
  end
`endif
endmodule
